// File: rtl/sprite_compositor.sv
// Raster-scan sprite compositor: walks a cursor over the frame, reads the background
// and sprite memories, and emits prioritised RGB565 pixels over a valid/ready handshake.
module sprite_compositor #(
  parameter int H_RES = 96,
  parameter int V_RES = 64,
  parameter int NSPR  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NSPR-1:0]      spr_en,
  input  logic [NSPR*10-1:0]   spr_x_flat,
  input  logic [NSPR*10-1:0]   spr_y_flat,
  input  logic [NSPR*2-1:0]    spr_dir_flat,
  output logic [9:0]           bg_x,
  output logic [9:0]           bg_y,
  output logic [NSPR*10-1:0]   spr_rel_x_flat,
  output logic [NSPR*10-1:0]   spr_rel_y_flat,
  output logic [NSPR*2-1:0]    spr_dir_out_flat,
  input  logic [17:0]          bg_data,
  input  logic [NSPR*18-1:0]   spr_data_flat,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [15:0]          pix_color,
  output logic [9:0]           pix_x,
  output logic [9:0]           pix_y,
  output logic                 pix_last,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [9:0]            r_ax;
  logic [9:0]            r_ay;
  logic [NSPR-1:0]       r_en_l;
  logic [NSPR*10-1:0]    r_sx_l;
  logic [NSPR*10-1:0]    r_sy_l;
  logic [NSPR*2-1:0]     r_dir_l;

  logic                  r_pix_valid;
  logic [15:0]           r_pix_color;
  logic [9:0]            r_pix_x;
  logic [9:0]            r_pix_y;
  logic                  r_pix_last;
  logic                  r_frame_done;

  logic                  w_snap;
  logic                  w_load;
  logic                  w_advance;
  logic                  w_done;
  logic                  w_at_end;
  logic                  w_at_eol;
  logic [15:0]           w_color;
  logic [NSPR*10-1:0]    w_rel_x;
  logic [NSPR*10-1:0]    w_rel_y;
  logic                  w_unused;

  assign w_at_eol = (r_ax == 10'(H_RES - 1));
  assign w_at_end = w_at_eol && (r_ay == 10'(V_RES - 1));

  // Disabled sprites are parked at the far corner of their memory, which reads as transparent.
  always_comb begin
    w_rel_x = '1;
    w_rel_y = '1;
    for (int unsigned i = 0; i < NSPR; i++) begin
      if (r_en_l[i]) begin
        w_rel_x[i*10 +: 10] = r_ax - r_sx_l[i*10 +: 10];
        w_rel_y[i*10 +: 10] = r_ay - r_sy_l[i*10 +: 10];
      end
    end
  end

  // Walk from the bottom layer upward so the lowest opaque index ends up on top.
  always_comb begin
    w_color = bg_data[17:2];
    for (int unsigned i = NSPR; i > 0; i--) begin
      if (r_en_l[i-1] && (spr_data_flat[(i-1)*18 +: 2] != 2'b01)) begin
        w_color = spr_data_flat[(i-1)*18 + 2 +: 16];
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_snap    = 1'b0;
    w_load    = 1'b0;
    w_advance = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_snap = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next = S_LOAD;
      end
      S_LOAD: begin
        if (!r_pix_valid || pix_ready) begin
          w_load = 1'b1;
          if (w_at_end) begin
            w_next = S_DRAIN;
          end else begin
            w_advance = 1'b1;
            w_next    = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (r_pix_valid && pix_ready) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ax    <= '0;
      r_ay    <= '0;
      r_en_l  <= '0;
      r_sx_l  <= '0;
      r_sy_l  <= '0;
      r_dir_l <= '0;
    end else if (w_snap) begin
      r_ax    <= '0;
      r_ay    <= '0;
      r_en_l  <= spr_en;
      r_sx_l  <= spr_x_flat;
      r_sy_l  <= spr_y_flat;
      r_dir_l <= spr_dir_flat;
    end else if (w_advance) begin
      if (w_at_eol) begin
        r_ax <= '0;
        r_ay <= r_ay + 10'd1;
      end else begin
        r_ax <= r_ax + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_valid  <= 1'b0;
      r_pix_color  <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      if (w_load) begin
        r_pix_valid <= 1'b1;
        r_pix_color <= w_color;
        r_pix_x     <= r_ax;
        r_pix_y     <= r_ay;
        r_pix_last  <= w_at_end;
      end else if (r_pix_valid && pix_ready) begin
        r_pix_valid <= 1'b0;
      end
    end
  end

  assign w_unused         = &{1'b0, bg_data[1:0]};
  assign bg_x             = r_ax;
  assign bg_y             = r_ay;
  assign spr_rel_x_flat   = w_rel_x;
  assign spr_rel_y_flat   = w_rel_y;
  assign spr_dir_out_flat = r_dir_l;
  assign pix_valid        = r_pix_valid;
  assign pix_color        = r_pix_color;
  assign pix_x            = r_pix_x;
  assign pix_y            = r_pix_y;
  assign pix_last         = r_pix_last;
  assign busy             = (r_state != S_IDLE);
  assign frame_done       = r_frame_done;

endmodule
